uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
Parameters:
REQ-001 DATA_W, 8, maximum data bits per frame; legal range 5-9.
REQ-002 DIV_W, 12, width of the bit-period divisor input.
Ports:
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tx_data  input  DATA_W  frame payload, LSB transmitted first.
REQ-006 tx_valid  input  1  payload and config valid.
REQ-007 tx_ready  output  1  holding buffer empty; handshake completes when tx_valid & tx_ready are both high at a clock edge.
REQ-008 cfg_nbits  input  4  data bits per frame, 1..DATA_W; 0 or >DATA_W SHALL be treated as DATA_W.
REQ-009 cfg_parity  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-010 cfg_stop2  input  1  0 one stop bit, 1 two stop bits.
REQ-011 cfg_div  input  DIV_W  clocks per bit; values <2 SHALL be treated as 2.
REQ-012 txd  output  1  serial line, idle high, registered.
REQ-013 busy  output  1  high while any frame bit, including stop bits, is on txd.

Function
REQ-014 Frame SHALL be: start (0), cfg_nbits data bits LSB first, optional parity, 1 or 2 stop bits (1).
REQ-015 Even parity SHALL make the count of 1s across data+parity even; odd SHALL make it odd; only the cfg_nbits transmitted bits count.
REQ-016 tx_data and all cfg_* SHALL be captured into a one-entry holding buffer at handshake; later changes on these inputs SHALL NOT affect that frame.
REQ-017 tx_ready SHALL be high whenever the holding buffer is empty, including mid-frame, so the next frame can be queued during transmission.
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP; every non-IDLE state lasts exactly div clocks per bit, div being the effective divisor captured with the frame.
REQ-019 IDLE -> START when the holding buffer is full; buffer moves into the shift register and empties in that same cycle.
REQ-020 START -> DATA; DATA -> PARITY after the last data bit if parity is enabled, else -> STOP; PARITY -> STOP; STOP -> START if the buffer is full at the end of the final stop bit (no idle gap), else -> IDLE.
REQ-021 From IDLE, a handshake at edge N SHALL drive txd low from edge N+1; with no gap, the next start bit SHALL immediately follow the last stop bit.
REQ-022 The bit-period counter SHALL restart at every bit boundary; bit boundaries SHALL never drift across frames.
REQ-023 A handshake in the same cycle the buffer drains to the shift register SHALL be accepted: tx_ready is already high that cycle and the new entry is written while the old one is read out.
REQ-024 tx_valid while tx_ready low SHALL be ignored; the source holds data until acceptance.
REQ-025 busy SHALL fall on the same edge txd returns to IDLE; tx_ready SHALL never depend combinationally on tx_valid.

Reset
REQ-026 On reset assertion, regardless of frame progress: state IDLE, txd 1, busy 0, tx_ready 1, holding buffer empty, counters 0.
REQ-027 A frame interrupted by reset SHALL be abandoned, not resumed; the first frame after deassertion starts no earlier than one clock after reset release.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state type, the parity-mode encodings, and the minimum-divisor constant (2).
REQ-029 One sub-module, uart_baud_cnt (DIV_W-wide down-counter with load and bit_tick output), SHALL be instantiated; everything else SHALL be in uart_tx_param.

Verification
REQ-030 div=4, nbits=8, parity none, stop1, data 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; busy high 40 clocks.
REQ-031 div=3, nbits=7, even parity, data 0x03 -> 7 data bits 1100000, parity 0; odd parity -> parity 1; frame 10 bits = 30 clocks.
REQ-032 div=2, stop2, two frames offered back-to-back (0x55 then 0x0F) -> second queued mid-frame, tx_ready falls for it, second start bit directly after the second stop bit of frame 1, no idle cycle.
REQ-033 cfg_div=0 and cfg_nbits=0 with DATA_W=8 -> behaves as div=2, 8 data bits.
REQ-034 reset asserted during DATA bit 3 -> txd 1, busy 0, tx_ready 1 asynchronously; next frame after release transmits cleanly from its start bit.
REQ-035 cfg_* and tx_data changed one cycle after handshake -> transmitted frame matches captured values.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the parameterised UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  localparam int unsigned MIN_DIV = 2;

  // A parity bit is sent only for the even and odd encodings.
  function automatic logic parity_en(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: reloaded at each bit boundary, ticks when it hits zero.
module uart_baud_cnt #(
  parameter int unsigned DIV_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_val_i,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Load wins; otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with per-frame data width, parity, stop bits and divisor,
// fronted by a one-entry holding buffer so frames can be queued mid-frame.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [3:0]        cfg_nbits,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              txd,
  output logic              busy
);

  localparam logic [3:0]       NB_MAX  = 4'(DATA_W);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(MIN_DIV);

  // Holding buffer (config stored already normalised).
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [3:0]        hold_nbits_q, hold_nbits_d;
  logic [1:0]        hold_par_q, hold_par_d;
  logic              hold_stop2_q, hold_stop2_d;
  logic [DIV_W-1:0]  hold_div_q, hold_div_d;

  // Active frame.
  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [3:0]        nbits_q, nbits_d;
  logic [1:0]        par_mode_q, par_mode_d;
  logic              stop2_q, stop2_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [3:0]        bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic              par_acc_q, par_acc_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              rdy_q, rdy_d;

  logic              hs_c;
  logic              drain_c;
  logic              cnt_load_c;
  logic [DIV_W-1:0]  cnt_load_val_c;
  logic              bit_tick;
  logic [3:0]        nbits_eff_c;
  logic [DIV_W-1:0]  div_eff_c;

  assign hs_c        = tx_valid & rdy_q;
  assign nbits_eff_c = ((cfg_nbits == 4'd0) || (cfg_nbits > NB_MAX)) ? NB_MAX : cfg_nbits;
  assign div_eff_c   = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;

  uart_baud_cnt #(.DIV_W(DIV_W)) u_baud (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load_c),
    .load_val_i (cnt_load_val_c),
    .bit_tick   (bit_tick)
  );

  // Frame sequencing, shift register, counter control and holding buffer.
  always_comb begin
    state_d        = state_q;
    sh_d           = sh_q;
    nbits_d        = nbits_q;
    par_mode_d     = par_mode_q;
    stop2_d        = stop2_q;
    div_d          = div_q;
    bit_idx_d      = bit_idx_q;
    stop_idx_d     = stop_idx_q;
    par_acc_d      = par_acc_q;
    txd_d          = txd_q;
    busy_d         = busy_q;
    drain_c        = 1'b0;
    cnt_load_c     = 1'b0;
    cnt_load_val_c = div_q - DIV_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (hold_full_q) begin
          drain_c = 1'b1;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_d    = ST_DATA;
          txd_d      = sh_q[0];
          par_acc_d  = sh_q[0];
          sh_d       = sh_q >> 1;
          bit_idx_d  = 4'd1;
          cnt_load_c = 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          cnt_load_c = 1'b1;
          if (bit_idx_q == nbits_q) begin
            if (parity_en(par_mode_q)) begin
              state_d = ST_PARITY;
              txd_d   = par_acc_q ^ (par_mode_q == PAR_ODD);
            end else begin
              state_d    = ST_STOP;
              txd_d      = 1'b1;
              stop_idx_d = 1'b0;
            end
          end else begin
            txd_d     = sh_q[0];
            par_acc_d = par_acc_q ^ sh_q[0];
            sh_d      = sh_q >> 1;
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_d    = ST_STOP;
          txd_d      = 1'b1;
          stop_idx_d = 1'b0;
          cnt_load_c = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
            txd_d      = 1'b1;
            cnt_load_c = 1'b1;
          end else if (hold_full_q) begin
            drain_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Move the buffered frame into the shift register and start it.
    if (drain_c) begin
      state_d        = ST_START;
      txd_d          = 1'b0;
      busy_d         = 1'b1;
      sh_d           = hold_data_q;
      nbits_d        = hold_nbits_q;
      par_mode_d     = hold_par_q;
      stop2_d        = hold_stop2_q;
      div_d          = hold_div_q;
      bit_idx_d      = 4'd0;
      stop_idx_d     = 1'b0;
      par_acc_d      = 1'b0;
      cnt_load_c     = 1'b1;
      cnt_load_val_c = hold_div_q - DIV_W'(1);
    end
  end

  // Holding buffer: a write in the same cycle as a drain refills it.
  always_comb begin
    hold_full_d  = hold_full_q;
    hold_data_d  = hold_data_q;
    hold_nbits_d = hold_nbits_q;
    hold_par_d   = hold_par_q;
    hold_stop2_d = hold_stop2_q;
    hold_div_d   = hold_div_q;
    if (drain_c) begin
      hold_full_d = 1'b0;
    end
    if (hs_c) begin
      hold_full_d  = 1'b1;
      hold_data_d  = tx_data;
      hold_nbits_d = nbits_eff_c;
      hold_par_d   = cfg_parity;
      hold_stop2_d = cfg_stop2;
      hold_div_d   = div_eff_c;
    end
    rdy_d = ~hold_full_d;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      sh_q         <= '0;
      nbits_q      <= '0;
      par_mode_q   <= PAR_NONE;
      stop2_q      <= 1'b0;
      div_q        <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      par_acc_q    <= 1'b0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
      rdy_q        <= 1'b1;
      hold_full_q  <= 1'b0;
      hold_data_q  <= '0;
      hold_nbits_q <= '0;
      hold_par_q   <= PAR_NONE;
      hold_stop2_q <= 1'b0;
      hold_div_q   <= '0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      nbits_q      <= nbits_d;
      par_mode_q   <= par_mode_d;
      stop2_q      <= stop2_d;
      div_q        <= div_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      par_acc_q    <= par_acc_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
      rdy_q        <= rdy_d;
      hold_full_q  <= hold_full_d;
      hold_data_q  <= hold_data_d;
      hold_nbits_q <= hold_nbits_d;
      hold_par_q   <= hold_par_d;
      hold_stop2_q <= hold_stop2_d;
      hold_div_q   <= hold_div_d;
    end
  end

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign tx_ready = rdy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: accepted frames are queued with their
// normalised config and compared clock-by-clock against the serial line.
module tb_uart_tx_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [3:0]  cfg_nbits = '0;
  logic [1:0]  cfg_parity = '0;
  logic        cfg_stop2 = 1'b0;
  logic [11:0] cfg_div = '0;
  logic        txd;
  logic        busy;

  typedef struct {
    logic [7:0] data;
    int         nb;
    logic [1:0] par;
    bit         stop2;
    int         div;
    int         hs;
  } item_t;

  item_t sb[$];
  int    n_checks = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    last_end = 0;

  uart_tx_param #(.DATA_W(8), .DIV_W(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .cfg_nbits  (cfg_nbits),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .cfg_div    (cfg_div),
    .txd        (txd),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer one frame, wait for acceptance, queue its expected form, then scramble inputs.
  task automatic send(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] par,
                      input bit st2, input logic [11:0] dv);
    item_t it;
    int    w;
    @(negedge clk);
    tx_data    = d;
    cfg_nbits  = nb;
    cfg_parity = par;
    cfg_stop2  = st2;
    cfg_div    = dv;
    tx_valid   = 1'b1;
    w = 0;
    while (tx_ready !== 1'b1) begin
      @(negedge clk);
      w++;
      if (w > 3000) begin
        chk("ready_timeout", 0, 1);
        tx_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    @(negedge clk);
    it.data  = d;
    it.nb    = (nb == 0 || nb > 8) ? 8 : int'(nb);
    it.par   = par;
    it.stop2 = st2;
    it.div   = (dv < 2) ? 2 : int'(dv);
    it.hs    = cyc - 1;
    sb.push_back(it);
    tx_valid   = 1'b0;
    tx_data    = ~d;
    cfg_nbits  = nb + 4'd3;
    cfg_parity = ~par;
    cfg_stop2  = ~st2;
    cfg_div    = dv + 12'd7;
    chk("ready_low_after_hs", 32'(tx_ready), 0);
  endtask

  // Wait for a start bit, pop the scoreboard and compare every bit period.
  task automatic recv(input bit chk_lat, input bit chk_b2b);
    item_t it;
    logic  eb[16];
    int    okc[16];
    int    nbit;
    int    w;
    int    b;
    logic  p;
    w = 0;
    while (1) begin
      @(negedge clk);
      if (txd === 1'b0) break;
      w++;
      if (w > 3000) begin
        chk("start_timeout", 0, 1);
        return;
      end
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    it = sb.pop_front();
    if (chk_lat) chk("latency", 32'(cyc - it.hs), 2);
    if (chk_b2b) chk("no_gap", 32'(cyc - last_end), 1);
    nbit = 0;
    eb[nbit++] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < it.nb; i++) begin
      eb[nbit++] = it.data[i];
      p = p ^ it.data[i];
    end
    if (it.par == 2'b01) eb[nbit++] = p;
    if (it.par == 2'b10) eb[nbit++] = ~p;
    eb[nbit++] = 1'b1;
    if (it.stop2) eb[nbit++] = 1'b1;
    for (int i = 0; i < 16; i++) okc[i] = 0;
    for (int c = 0; c < nbit * it.div; c++) begin
      if (c > 0) @(negedge clk);
      b = c / it.div;
      if (txd === eb[b] && busy === 1'b1) okc[b]++;
    end
    last_end = cyc;
    for (int i = 0; i < nbit; i++)
      chk($sformatf("bit%0d_d%02h", i, it.data), 32'(okc[i]), 32'(it.div));
  endtask

  task automatic post_idle(input string tag);
    @(negedge clk);
    chk({tag, "_txd"}, 32'(txd), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ready"}, 32'(tx_ready), 1);
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(tx_ready), 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5, div 4, 8N1
    fork
      send(8'hA5, 4'd8, 2'b00, 1'b0, 12'd4);
      recv(1'b1, 1'b0);
    join
    post_idle("a5");

    // 0x03, div 3, 7 bits even then odd
    fork
      send(8'h03, 4'd7, 2'b01, 1'b0, 12'd3);
      recv(1'b1, 1'b0);
    join
    post_idle("even");
    fork
      send(8'h03, 4'd7, 2'b10, 1'b0, 12'd3);
      recv(1'b1, 1'b0);
    join
    post_idle("odd");

    // Back-to-back with two stop bits, second queued mid-frame
    fork
      begin
        send(8'h55, 4'd8, 2'b00, 1'b1, 12'd2);
        send(8'h0F, 4'd8, 2'b00, 1'b1, 12'd2);
      end
      begin
        recv(1'b1, 1'b0);
        recv(1'b0, 1'b1);
      end
    join
    post_idle("b2b");

    // Degenerate config: div 0 and nbits 0 normalise to 2 and 8
    fork
      send(8'hC3, 4'd0, 2'b00, 1'b0, 12'd0);
      recv(1'b1, 1'b0);
    join
    post_idle("zero_cfg");

    // Oversized nbits, div 1, even parity
    fork
      send(8'h9E, 4'd12, 2'b01, 1'b0, 12'd1);
      recv(1'b1, 1'b0);
    join
    post_idle("big_nb");

    // Reset during data bit 3
    fork
      send(8'hA5, 4'd8, 2'b00, 1'b0, 12'd4);
      begin
        w = 0;
        while (txd !== 1'b0 && w < 3000) begin
          @(negedge clk);
          w++;
        end
        chk("rst_frame_started", 32'(txd), 0);
      end
    join
    repeat (17) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_txd", 32'(txd), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ready", 32'(tx_ready), 1);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_txd", 32'(txd), 1);
    chk("post_rst_busy", 32'(busy), 0);

    // Clean frame after reset: 6 bits, odd parity, two stops, div 5
    fork
      send(8'h5A, 4'd6, 2'b10, 1'b1, 12'd5);
      recv(1'b1, 1'b0);
    join
    post_idle("after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
